// File: rtl/cfu_mac_pkg.sv
// Shared definitions for the CFU MAC accumulator.
//   ACC_W / CNT_W : accumulator and operation-counter widths
//   OP_*          : function_id[2:0] operation encodings
//   state_e       : command FSM states
package cfu_mac_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] OP_ACC        = 3'd0;
  localparam logic [2:0] OP_CLEAR      = 3'd1;
  localparam logic [2:0] OP_SET        = 3'd2;
  localparam logic [2:0] OP_READ       = 3'd3;
  localparam logic [2:0] OP_ACC_SAT    = 3'd4;
  localparam logic [2:0] OP_READ_COUNT = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/cfu_sat_add.sv
// Combinational signed adder with wrap or saturate result.
//   a, b     : signed 32-bit operands
//   sat      : 1 = clamp to 0x7FFFFFFF / 0x80000000 on overflow, 0 = wrap
//   sum      : 32-bit result
//   overflow : signed overflow of the true sum
module cfu_sat_add
  import cfu_mac_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sat,
  output logic [ACC_W-1:0] sum,
  output logic             overflow
);

  logic [ACC_W:0] sum_ext;

  // Sign-extended to 33 bits: overflow iff the top two bits disagree.
  assign sum_ext  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
  assign overflow = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];

  always_comb begin
    sum = sum_ext[ACC_W-1:0];
    if (sat && overflow) begin
      // Bit 32 carries the true sign of the result.
      sum = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cfu_mac_accumulator.sv
// CFU accumulate stage: takes signed products over a valid/ready command
// channel, updates a 32-bit accumulator and a 16-bit op counter, and returns
// one response per command over a valid/ready response channel.
//   clk, reset (async, active low)
//   cmd_valid/cmd_ready, cmd_payload_function_id[9:0],
//   cmd_payload_inputs_0 (product), cmd_payload_inputs_1 (SET value)
//   rsp_valid/rsp_ready, rsp_payload_outputs_0
//   acc_overflow (sticky), cmd_illegal (sticky)
module cfu_mac_accumulator
  import cfu_mac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        acc_overflow,
  output logic        cmd_illegal
);

  state_e             state_q, state_d;
  logic [9:0]         func_q;
  logic [ACC_W-1:0]   in0_q, in1_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   rsp_q, rsp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic               accept;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;

  // Gated with reset so the channel is never offered while held in reset.
  assign cmd_ready = (state_q == StIdle) && reset;
  assign accept    = cmd_valid && cmd_ready;

  assign rsp_valid             = (state_q == StResp);
  assign rsp_payload_outputs_0 = rsp_q;
  assign acc_overflow          = ovf_q;
  assign cmd_illegal           = ill_q;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  cfu_sat_add u_sat_add (
    .a        (acc_q),
    .b        (in0_q),
    .sat      (func_q[2:0] == OP_ACC_SAT),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StExec;
      end
      StExec: begin
        state_d = StResp;
        rsp_d   = '0;
        if (func_q[9:3] != 7'd0) begin
          ill_d = 1'b1;
        end else begin
          case (func_q[2:0])
            OP_ACC, OP_ACC_SAT: begin
              acc_d = add_sum;
              rsp_d = add_sum;
              cnt_d = cnt_inc;
              if (add_ovf) ovf_d = 1'b1;
            end
            OP_CLEAR: begin
              acc_d = '0;
              cnt_d = '0;
              ovf_d = 1'b0;
              ill_d = 1'b0;
            end
            OP_SET: begin
              acc_d = in1_q;
              rsp_d = acc_q;
            end
            OP_READ:       rsp_d = acc_q;
            OP_READ_COUNT: rsp_d = {{(ACC_W-CNT_W){1'b0}}, cnt_q};
            default:       ill_d = 1'b1;
          endcase
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      func_q  <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      acc_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
      if (accept) begin
        func_q <= cmd_payload_function_id;
        in0_q  <= cmd_payload_inputs_0;
        in1_q  <= cmd_payload_inputs_1;
      end
    end
  end

endmodule

// File: tb/tb_cfu_mac_accumulator.sv
module tb_cfu_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  fid;
  logic [31:0] in0, in1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        acc_overflow;
  logic        cmd_illegal;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] F_ACC   = 10'd0;
  localparam logic [9:0] F_CLEAR = 10'd1;
  localparam logic [9:0] F_SET   = 10'd2;
  localparam logic [9:0] F_READ  = 10'd3;
  localparam logic [9:0] F_SAT   = 10'd4;
  localparam logic [9:0] F_RCNT  = 10'd5;

  always #5 clk = ~clk;

  cfu_mac_accumulator dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (fid),
    .cmd_payload_inputs_0    (in0),
    .cmd_payload_inputs_1    (in1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_data),
    .acc_overflow            (acc_overflow),
    .cmd_illegal             (cmd_illegal)
  );

  // Drives one command through both handshakes and returns the response data.
  task automatic do_cmd(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r);
    int n;
    r = 32'hDEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b1; fid = f; in0 = a; in1 = b;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
      return;
    end
    r = rsp_data;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;
    #3;
    total++;
    if ({cmd_ready, rsp_valid, acc_overflow, cmd_illegal} !== 4'b0000 || rsp_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b vld=%b ovf=%b ill=%b data=%h required all 0",
               cmd_ready, rsp_valid, acc_overflow, cmd_illegal, rsp_data);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_acc();
    logic [31:0] r;
    do_cmd(F_ACC, 32'd5, 32'd0, r);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL acc_5: got %h required 5", r); end
    do_cmd(F_ACC, 32'hFFFF_FFFD, 32'd0, r);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL acc_m3: got %h required 2", r); end
    do_cmd(F_READ, 32'd0, 32'd0, r);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL read_2: got %h required 2", r); end
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL count_2: got %h required 2", r); end
    total++;
    if (acc_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got %b required 0", acc_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    do_cmd(F_SET, 32'd0, 32'h7FFF_FFF0, r);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL set_old: got %h required 2", r); end
    do_cmd(F_ACC, 32'h20, 32'd0, r);
    total++;
    if (r !== 32'h8000_0010) begin bad++; $display("FAIL wrap: got %h required 80000010", r); end
    total++;
    if (acc_overflow !== 1'b1) begin bad++; $display("FAIL wrap_ovf: got %b required 1", acc_overflow); end
    do_cmd(F_CLEAR, 32'd0, 32'd0, r);
    total++;
    if (r !== 32'd0 || acc_overflow !== 1'b0) begin
      bad++; $display("FAIL clear: data=%h ovf=%b required 0 0", r, acc_overflow);
    end
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL clear_count: got %h required 0", r); end
  endtask

  task automatic test_sat();
    logic [31:0] r;
    do_cmd(F_SET, 32'd0, 32'h7FFF_FFF0, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL set_old0: got %h required 0", r); end
    do_cmd(F_SAT, 32'h20, 32'd0, r);
    total++;
    if (r !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sat_pos: got %h required 7fffffff", r); end
    do_cmd(F_SET, 32'd0, 32'h8000_0005, r);
    total++;
    if (r !== 32'h7FFF_FFFF) begin bad++; $display("FAIL set_oldmax: got %h required 7fffffff", r); end
    do_cmd(F_SAT, 32'hFFFF_FFF0, 32'd0, r);
    total++;
    if (r !== 32'h8000_0000) begin bad++; $display("FAIL sat_neg: got %h required 80000000", r); end
    total++;
    if (acc_overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf: got %b required 1", acc_overflow); end
    do_cmd(F_SAT, 32'd5, 32'd0, r);
    total++;
    if (r !== 32'h8000_0005) begin bad++; $display("FAIL sat_nosat: got %h required 80000005", r); end
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL sat_count: got %h required 3", r); end
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; fid = F_READ;
    @(posedge clk); #1;
    // Next command presented immediately and held while the response stalls.
    fid = F_RCNT;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      bad++; $display("FAIL exec_cycle: vld=%b rdy=%b required 0 0", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000_0005) begin
      bad++; $display("FAIL latency: vld=%b data=%h required 1 80000005", rsp_valid, rsp_data);
    end
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h8000_0005 || cmd_ready !== 1'b0) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL hold_stable: unstable cycles=%0d required 0", n); end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL back_idle: vld=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("FAIL pending_accept: rdy=%b required 0", cmd_ready); end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd3) begin
      bad++; $display("FAIL pending_rsp: vld=%b data=%h required 1 3", rsp_valid, rsp_data);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    do_cmd(10'h008, 32'd7, 32'd9, r);
    total++;
    if (r !== 32'd0 || cmd_illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_hi: data=%h ill=%b required 0 1", r, cmd_illegal);
    end
    do_cmd(10'd7, 32'd7, 32'd9, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL illegal_op7: got %h required 0", r); end
    do_cmd(F_READ, 32'd0, 32'd0, r);
    total++;
    if (r !== 32'h8000_0005) begin bad++; $display("FAIL illegal_acc: got %h required 80000005", r); end
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'd3) begin bad++; $display("FAIL illegal_cnt: got %h required 3", r); end
  endtask

  task automatic test_reset_in_resp();
    logic [31:0] r;
    @(negedge clk);
    cmd_valid = 1'b1; fid = F_READ;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b1) begin bad++; $display("FAIL resp_before_rst: got %b required 1", rsp_valid); end
    #2; reset = 1'b0; #1;
    total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || cmd_illegal !== 1'b0) begin
      bad++; $display("FAIL async_drop: vld=%b rdy=%b ill=%b required 0 0 0",
                      rsp_valid, cmd_ready, cmd_illegal);
    end
    @(negedge clk); reset = 1'b1;
    do_cmd(F_READ, 32'd0, 32'd0, r);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL post_rst_read: got %h required 0", r); end
  endtask

  task automatic test_count_sat();
    logic [31:0] r;
    @(negedge clk);
    dut.cnt_q = 16'hFFFD;
    do_cmd(F_ACC, 32'd0, 32'd0, r);
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'h0000_FFFE) begin bad++; $display("FAIL count_fffe: got %h required fffe", r); end
    for (int i = 0; i < 3; i++) do_cmd(F_ACC, 32'd0, 32'd0, r);
    do_cmd(F_RCNT, 32'd0, 32'd0, r);
    total++; if (r !== 32'h0000_FFFF) begin bad++; $display("FAIL count_sat: got %h required ffff", r); end
  endtask

  initial begin
    test_reset();
    test_acc();
    test_wrap();
    test_sat();
    test_hold();
    test_illegal();
    test_reset_in_resp();
    test_count_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
